trap_ctrl: RTL and testbench

//  Trap/interrupt sequencer that owns the single CSR-file port (csr_addr/csr_we/csr_wdata -> csr, csr_out -> csr_rdata).
//  In IDLE it passes the pipeline's CSR-instruction access straight through to the CSR file.
//  On an exception, interrupt or mret it stalls the pipeline and walks mepc/mcause/mtval/mstatus/mtvec
//  one access per cycle, then issues a one-cycle PC redirect.

---
 rtl/trap_ctrl_pkg.sv | 47 ++++
 rtl/trap_ctrl_if.sv | 24 ++
 rtl/trap_irq_sel.sv | 37 +++
 rtl/trap_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants and types for the trap/interrupt sequencer: CSR addresses, status/enable
// bit positions, interrupt cause codes and FSM encodings.
package trap_ctrl_pkg;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMie     = 12'h304;
    localparam logic [11:0] CsrMtvec   = 12'h305;
    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMcause  = 12'h342;
    localparam logic [11:0] CsrMtval   = 12'h343;

    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;
    localparam int unsigned MstatusMppHi = 12;

    localparam int unsigned MieMsie = 3;
    localparam int unsigned MieMtie = 7;
    localparam int unsigned MieMeie = 11;

    localparam logic [4:0] IrqCodeSw    = 5'd3;
    localparam logic [4:0] IrqCodeTimer = 5'd7;
    localparam logic [4:0] IrqCodeExt   = 5'd11;

    typedef enum logic [3:0] {
        StIdle,
        StWEpc,
        StWCause,
        StWTval,
        StRStatus,
        StWStatus,
        StRTvec,
        StREpc,
        StRedirect
    } trap_state_e;

    typedef enum logic {
        ModeTrap,
        ModeMret
    } trap_mode_e;

    // Byte offset of a vectored interrupt handler from the mtvec base.
    function automatic logic [6:0] vec_offset(input logic [4:0] code);
        return {code, 2'b00};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// CSR-file port owned by the trap sequencer: address/write strobe/data out, combinational
// read data back.
interface trap_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;

    modport master (
        output csr_addr,
        output csr_we,
        output csr_wdata,
        input  csr_rdata
    );

    modport slave (
        input  csr_addr,
        input  csr_we,
        input  csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/trap_irq_sel.sv
// Interrupt enable mask plus fixed-priority encoder (external > software > timer).
module trap_irq_sel
    import trap_ctrl_pkg::*;
(
    input  logic       sh_mie,
    input  logic       sh_meie,
    input  logic       sh_msie,
    input  logic       sh_mtie,
    input  logic       irq_ext,
    input  logic       irq_sw,
    input  logic       irq_timer,
    output logic       irq_take,
    output logic [4:0] irq_code
);
    logic ext_en;
    logic sw_en;
    logic timer_en;

    assign ext_en   = sh_mie & sh_meie & irq_ext;
    assign sw_en    = sh_mie & sh_msie & irq_sw;
    assign timer_en = sh_mie & sh_mtie & irq_timer;

    always_comb begin
        irq_take = 1'b0;
        irq_code = 5'd0;
        if (ext_en) begin
            irq_take = 1'b1;
            irq_code = IrqCodeExt;
        end else if (sw_en) begin
            irq_take = 1'b1;
            irq_code = IrqCodeSw;
        end else if (timer_en) begin
            irq_take = 1'b1;
            irq_code = IrqCodeTimer;
        end
    end
endmodule

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: passes pipeline CSR accesses through when idle, otherwise stalls and
// walks the trap-entry or mret CSR sequence one access per cycle, ending in a PC redirect.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [XLEN-1:0]  exc_tval,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             irq_ext,
    input  logic             irq_sw,
    input  logic             irq_timer,
    input  logic             mret_valid,
    input  logic [11:0]      instr_csr_addr,
    input  logic             instr_csr_we,
    input  logic [XLEN-1:0]  instr_csr_wdata,
    trap_ctrl_if.master      csr,
    output logic             stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);
    trap_state_e     state_q, state_d;
    trap_mode_e      mode_q, mode_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] st_q, st_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            sh_mie_q, sh_mie_d;
    logic            sh_meie_q, sh_meie_d;
    logic            sh_msie_q, sh_msie_d;
    logic            sh_mtie_q, sh_mtie_d;

    logic            irq_take;
    logic [4:0]      irq_code;
    logic [XLEN-1:0] status_new;
    logic [XLEN-1:0] tvec_base;
    logic            vec_hit;
    logic [XLEN-1:0] trap_target;

    trap_irq_sel u_irq_sel (
        .sh_mie    (sh_mie_q),
        .sh_meie   (sh_meie_q),
        .sh_msie   (sh_msie_q),
        .sh_mtie   (sh_mtie_q),
        .irq_ext   (irq_ext),
        .irq_sw    (irq_sw),
        .irq_timer (irq_timer),
        .irq_take  (irq_take),
        .irq_code  (irq_code)
    );

    // tgt_q holds mtvec during trap entry; only interrupts may use vectored mode.
    assign tvec_base   = {tgt_q[XLEN-1:2], 2'b00};
    assign vec_hit     = VECTORED_EN && (tgt_q[1:0] == 2'b01) && cause_q[XLEN-1];
    assign trap_target = vec_hit ? tvec_base + XLEN'(vec_offset(cause_q[4:0])) : tvec_base;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cause_d    = cause_q;
        tval_d     = tval_q;
        pc_d       = pc_q;
        st_d       = st_q;
        tgt_d      = tgt_q;
        rpc_d      = rpc_q;
        sh_mie_d   = sh_mie_q;
        sh_meie_d  = sh_meie_q;
        sh_msie_d  = sh_msie_q;
        sh_mtie_d  = sh_mtie_q;
        status_new = st_q;

        csr.csr_addr   = instr_csr_addr;
        csr.csr_we     = 1'b0;
        csr.csr_wdata  = instr_csr_wdata;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = rpc_q;

        unique case (state_q)
            StIdle: begin
                stall = 1'b0;
                if (exc_valid) begin
                    stall   = 1'b1;
                    state_d = StWEpc;
                    mode_d  = ModeTrap;
                    cause_d = {{(XLEN-5){1'b0}}, exc_code};
                    tval_d  = exc_tval;
                    pc_d    = trap_pc;
                end else if (irq_take) begin
                    stall   = 1'b1;
                    state_d = StWEpc;
                    mode_d  = ModeTrap;
                    cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
                    tval_d  = '0;
                    pc_d    = trap_pc;
                end else if (mret_valid) begin
                    stall   = 1'b1;
                    state_d = StRStatus;
                    mode_d  = ModeMret;
                end else begin
                    // Only writes that actually reach the CSR file update the shadows.
                    csr.csr_we = instr_csr_we;
                    if (instr_csr_we && instr_csr_addr == CsrMstatus) begin
                        sh_mie_d = instr_csr_wdata[MstatusMie];
                    end
                    if (instr_csr_we && instr_csr_addr == CsrMie) begin
                        sh_meie_d = instr_csr_wdata[MieMeie];
                        sh_msie_d = instr_csr_wdata[MieMsie];
                        sh_mtie_d = instr_csr_wdata[MieMtie];
                    end
                end
            end
            StWEpc: begin
                csr.csr_addr  = CsrMepc;
                csr.csr_we    = 1'b1;
                csr.csr_wdata = pc_q;
                state_d       = StWCause;
            end
            StWCause: begin
                csr.csr_addr  = CsrMcause;
                csr.csr_we    = 1'b1;
                csr.csr_wdata = cause_q;
                state_d       = StWTval;
            end
            StWTval: begin
                csr.csr_addr  = CsrMtval;
                csr.csr_we    = 1'b1;
                csr.csr_wdata = tval_q;
                state_d       = StRStatus;
            end
            StRStatus: begin
                csr.csr_addr = CsrMstatus;
                st_d         = csr.csr_rdata;
                state_d      = StWStatus;
            end
            StWStatus: begin
                if (mode_q == ModeTrap) begin
                    status_new[MstatusMpie] = st_q[MstatusMie];
                    status_new[MstatusMie]  = 1'b0;
                    sh_mie_d                = 1'b0;
                    state_d                 = StRTvec;
                end else begin
                    status_new[MstatusMie]  = st_q[MstatusMpie];
                    status_new[MstatusMpie] = 1'b1;
                    sh_mie_d                = st_q[MstatusMpie];
                    state_d                 = StREpc;
                end
                status_new[MstatusMppHi:MstatusMppLo] = 2'b11;
                csr.csr_addr  = CsrMstatus;
                csr.csr_we    = 1'b1;
                csr.csr_wdata = status_new;
            end
            StRTvec: begin
                csr.csr_addr = CsrMtvec;
                tgt_d        = csr.csr_rdata;
                state_d      = StRedirect;
            end
            StREpc: begin
                csr.csr_addr = CsrMepc;
                tgt_d        = csr.csr_rdata;
                state_d      = StRedirect;
            end
            StRedirect: begin
                redirect_valid = 1'b1;
                redirect_pc    = (mode_q == ModeMret) ? tgt_q : trap_target;
                rpc_d          = redirect_pc;
                state_d        = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            mode_q    <= ModeTrap;
            cause_q   <= '0;
            tval_q    <= '0;
            pc_q      <= '0;
            st_q      <= '0;
            tgt_q     <= '0;
            rpc_q     <= '0;
            sh_mie_q  <= 1'b0;
            sh_meie_q <= 1'b0;
            sh_msie_q <= 1'b0;
            sh_mtie_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cause_q   <= cause_d;
            tval_q    <= tval_d;
            pc_q      <= pc_d;
            st_q      <= st_d;
            tgt_q     <= tgt_d;
            rpc_q     <= rpc_d;
            sh_mie_q  <= sh_mie_d;
            sh_meie_q <= sh_meie_d;
            sh_msie_q <= sh_msie_d;
            sh_mtie_q <= sh_mtie_d;
        end
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: a negedge-write CSR-file model, expected CSR writes and
// redirects queued at stimulus time and popped by a monitor whenever the DUT presents them.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam logic [11:0] CsrMscratch = 12'h340;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            exc_valid;
    logic [4:0]      exc_code;
    logic [XLEN-1:0] exc_tval;
    logic [XLEN-1:0] trap_pc;
    logic            irq_ext;
    logic            irq_sw;
    logic            irq_timer;
    logic            mret_valid;
    logic [11:0]     instr_csr_addr;
    logic            instr_csr_we;
    logic [XLEN-1:0] instr_csr_wdata;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    trap_ctrl_if #(.XLEN(XLEN)) csr_bus ();

    trap_ctrl #(
        .XLEN        (XLEN),
        .VECTORED_EN (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .exc_valid       (exc_valid),
        .exc_code        (exc_code),
        .exc_tval        (exc_tval),
        .trap_pc         (trap_pc),
        .irq_ext         (irq_ext),
        .irq_sw          (irq_sw),
        .irq_timer       (irq_timer),
        .mret_valid      (mret_valid),
        .instr_csr_addr  (instr_csr_addr),
        .instr_csr_we    (instr_csr_we),
        .instr_csr_wdata (instr_csr_wdata),
        .csr             (csr_bus),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    // CSR file model: combinational read, write on negedge.
    bit [31:0] csr_mem [4096];
    assign csr_bus.csr_rdata = csr_mem[csr_bus.csr_addr];
    always @(negedge clk) begin
        if (csr_bus.csr_we) csr_mem[csr_bus.csr_addr] <= csr_bus.csr_wdata;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef struct {
        logic [31:0] pc;
        int unsigned at;
    } rd_t;

    wr_t exp_wr[$];
    rd_t exp_rd[$];
    int  checks = 0;
    int  errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes a CSR or strobes a redirect.
    always @(negedge clk) begin
        wr_t w;
        rd_t r;
        if (csr_bus.csr_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected",
                         csr_bus.csr_addr, csr_bus.csr_wdata);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", {20'd0, csr_bus.csr_addr}, {20'd0, w.addr});
                chk("wr_data", csr_bus.csr_wdata, w.data);
            end
        end
        if (redirect_valid) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_redirect: pc 0x%08h, none expected", redirect_pc);
            end else begin
                r = exp_rd.pop_front();
                chk("redirect_pc", redirect_pc, r.pc);
                chk("redirect_cycle", cyc, r.at);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_valid       = 1'b0;
        exc_code        = '0;
        exc_tval        = '0;
        trap_pc         = '0;
        irq_ext         = 1'b0;
        irq_sw          = 1'b0;
        irq_timer       = 1'b0;
        mret_valid      = 1'b0;
        instr_csr_addr  = '0;
        instr_csr_we    = 1'b0;
        instr_csr_wdata = '0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        exp_wr.push_back('{addr: addr, data: data});
        instr_csr_addr  = addr;
        instr_csr_we    = 1'b1;
        instr_csr_wdata = data;
        step();
        instr_csr_we    = 1'b0;
    endtask

    task automatic push_trap(input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] tval, input logic [31:0] status);
        exp_wr.push_back('{addr: CsrMepc, data: pc});
        exp_wr.push_back('{addr: CsrMcause, data: cause});
        exp_wr.push_back('{addr: CsrMtval, data: tval});
        exp_wr.push_back('{addr: CsrMstatus, data: status});
    endtask

    // From the accept cycle: stall high through the redirect at accept+n, low the cycle after.
    task automatic run_seq(input int unsigned n);
        for (int unsigned i = 0; i <= n; i++) begin
            @(negedge clk);
            chk($sformatf("stall_c%0d", i), {31'd0, stall}, 32'd1);
            step();
            clear_inputs();
        end
        @(negedge clk);
        chk("stall_idle", {31'd0, stall}, 32'd0);
        step();
    endtask

    int unsigned acc;

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_csr_we", {31'd0, csr_bus.csr_we}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // 1: exception, direct mtvec
        csr_write(CsrMtvec, 32'h200);
        csr_write(CsrMstatus, 32'h8);
        exc_valid = 1'b1; exc_code = 5'd2; trap_pc = 32'h100; exc_tval = 32'h13;
        acc = cyc;
        push_trap(32'h100, 32'd2, 32'h13, 32'h1880);
        exp_rd.push_back('{pc: 32'h200, at: acc + 7});
        run_seq(7);

        // 2: vectored timer interrupt
        csr_write(CsrMtvec, 32'h301);
        csr_write(CsrMstatus, 32'h8);
        csr_write(CsrMie, 32'h80);
        irq_timer = 1'b1; trap_pc = 32'h40;
        acc = cyc;
        push_trap(32'h40, 32'h8000_0007, 32'h0, 32'h1880);
        exp_rd.push_back('{pc: 32'h31C, at: acc + 7});
        run_seq(7);

        // 3: external interrupt masked by MIE=0, then unmasked by a CSR write
        csr_write(CsrMstatus, 32'h0);
        csr_write(CsrMie, 32'h800);
        irq_ext = 1'b1; trap_pc = 32'h80;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("masked_stall_%0d", i), {31'd0, stall}, 32'd0);
            step();
        end
        csr_write(CsrMstatus, 32'h8);
        acc = cyc;
        push_trap(32'h80, 32'h8000_000B, 32'h0, 32'h1880);
        exp_rd.push_back('{pc: 32'h32C, at: acc + 7});
        run_seq(7);

        // 4: mret
        csr_write(CsrMepc, 32'h104);
        csr_write(CsrMstatus, 32'h80);
        mret_valid = 1'b1;
        acc = cyc;
        exp_wr.push_back('{addr: CsrMstatus, data: 32'h1888});
        exp_rd.push_back('{pc: 32'h104, at: acc + 4});
        run_seq(4);

        // 5: simultaneous exception, enabled interrupt, mret and CSR write
        csr_write(CsrMscratch, 32'h55);
        exc_valid = 1'b1; exc_code = 5'd5; exc_tval = 32'h77; trap_pc = 32'h300;
        irq_ext = 1'b1; mret_valid = 1'b1;
        instr_csr_addr = CsrMscratch; instr_csr_we = 1'b1; instr_csr_wdata = 32'hAA;
        acc = cyc;
        push_trap(32'h300, 32'd5, 32'h77, 32'h1880);
        exp_rd.push_back('{pc: 32'h300, at: acc + 7});
        run_seq(7);
        chk("mscratch_kept", csr_mem[CsrMscratch], 32'h55);

        // 6: reset during W_STATUS, then a clean trap
        exc_valid = 1'b1; exc_code = 5'd4; exc_tval = 32'h9; trap_pc = 32'h500;
        exp_wr.push_back('{addr: CsrMepc, data: 32'h500});
        exp_wr.push_back('{addr: CsrMcause, data: 32'd4});
        exp_wr.push_back('{addr: CsrMtval, data: 32'h9});
        step();
        clear_inputs();
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("abort_redirect_pc", redirect_pc, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("abort_mepc_kept", csr_mem[CsrMepc], 32'h500);
        chk("abort_mstatus_kept", csr_mem[CsrMstatus], 32'h1880);

        exc_valid = 1'b1; exc_code = 5'd2; exc_tval = 32'h21; trap_pc = 32'h600;
        acc = cyc;
        push_trap(32'h600, 32'd2, 32'h21, 32'h1800);
        exp_rd.push_back('{pc: 32'h300, at: acc + 7});
        run_seq(7);
        repeat (2) step();
        chk("redirect_pc_hold", redirect_pc, 32'h300);

        chk("wr_queue_drained", exp_wr.size(), 32'd0);
        chk("rd_queue_drained", exp_rd.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
